// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: decodes row/col key strobes into 4-bit codes, edits an
// 8-code buffer and hands it off via valid/ready. Optional inactivity timeout: KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 500
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [7:0]  cur_key,
    input  logic        strobe,
    output logic [31:0] msg_o,
    output logic [3:0]  len_o,
    output logic        msg_valid_o,
    input  logic        msg_ready_i,
    output logic [3:0]  key_o,
    output logic        key_valid_o,
    output logic        err_o,
    output logic        timeout_o
);
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned MAX_LEN = 8;
    localparam logic [3:0]  CODE_BS    = 4'hD;
    localparam logic [3:0]  CODE_CLEAR = 4'hE;
    localparam logic [3:0]  CODE_SEND  = 4'hF;

    typedef enum logic {EDIT = 1'b0, SEND = 1'b1} state_t;

    state_t     state;
    logic [1:0] row_idx_c;
    logic [1:0] col_idx_c;
    logic       row_ok_c;
    logic       col_ok_c;
    logic [3:0] code_c;
    logic       accept_c;
    logic       timeout_hit_c;

    // One-hot row/col to index; anything not exactly one-hot per nibble is rejected
    always_comb begin
        row_idx_c = 2'd0;
        col_idx_c = 2'd0;
        row_ok_c  = 1'b1;
        col_ok_c  = 1'b1;
        case (cur_key[7:4])
            4'b1000: row_idx_c = 2'd0;
            4'b0100: row_idx_c = 2'd1;
            4'b0010: row_idx_c = 2'd2;
            4'b0001: row_idx_c = 2'd3;
            default: row_ok_c  = 1'b0;
        endcase
        case (cur_key[3:0])
            4'b1000: col_idx_c = 2'd0;
            4'b0100: col_idx_c = 2'd1;
            4'b0010: col_idx_c = 2'd2;
            4'b0001: col_idx_c = 2'd3;
            default: col_ok_c  = 1'b0;
        endcase
    end

    // Layout "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D"
    always_comb begin
        code_c = 4'h0;
        case ({row_idx_c, col_idx_c})
            4'd0:  code_c = 4'h1;
            4'd1:  code_c = 4'h2;
            4'd2:  code_c = 4'h3;
            4'd3:  code_c = 4'hA;
            4'd4:  code_c = 4'h4;
            4'd5:  code_c = 4'h5;
            4'd6:  code_c = 4'h6;
            4'd7:  code_c = 4'hB;
            4'd8:  code_c = 4'h7;
            4'd9:  code_c = 4'h8;
            4'd10: code_c = 4'h9;
            4'd11: code_c = 4'hC;
            4'd12: code_c = CODE_CLEAR;
            4'd13: code_c = 4'h0;
            4'd14: code_c = CODE_SEND;
            default: code_c = CODE_BS;
        endcase
    end

    assign accept_c = strobe && row_ok_c && col_ok_c;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;

    assign timeout_hit_c = (state == EDIT) && (len_o != '0) && !accept_c &&
                           (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle counter runs only while an unsent, non-empty entry sits in EDIT
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            idle_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_hit_c;
            if (state != EDIT || len_o == '0 || accept_c || timeout_hit_c)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg    = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit_c = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    // Entry FSM with registered outputs; msg_o is the edit buffer itself
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= EDIT;
            msg_o       <= '0;
            len_o       <= '0;
            msg_valid_o <= 1'b0;
            key_o       <= '0;
            key_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            case (state)
                EDIT: begin
                    if (accept_c) begin
                        key_o       <= code_c;
                        key_valid_o <= 1'b1;
                        if (code_c <= 4'h9) begin
                            if (len_o < LEN_W'(MAX_LEN)) begin
                                msg_o <= {msg_o[27:0], code_c};
                                len_o <= len_o + LEN_W'(1);
                            end else begin
                                err_o <= 1'b1;
                            end
                        end else if (code_c == CODE_BS) begin
                            if (len_o != '0) begin
                                msg_o <= msg_o >> 4;
                                len_o <= len_o - LEN_W'(1);
                            end
                        end else if (code_c == CODE_CLEAR) begin
                            msg_o <= '0;
                            len_o <= '0;
                            err_o <= 1'b0;
                        end else if (code_c == CODE_SEND) begin
                            if (len_o != '0) begin
                                state       <= SEND;
                                msg_valid_o <= 1'b1;
                            end
                        end
                    end else if (timeout_hit_c) begin
                        msg_o <= '0;
                        len_o <= '0;
                        err_o <= 1'b0;
                    end
                end
                SEND: begin
                    if (msg_ready_i) begin
                        state       <= EDIT;
                        msg_valid_o <= 1'b0;
                        msg_o       <= '0;
                        len_o       <= '0;
                        err_o       <= 1'b0;
                    end
                    // A dropped key flags an error even on the handshake cycle
                    if (accept_c)
                        err_o <= 1'b1;
                end
                default: state <= EDIT;
            endcase
        end
    end

endmodule
